// File: rtl/lc3b_types.sv
// Shared LC-3b types for the pipeline front end.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // FETCH: request outstanding; HOLD: word parked behind a stall;
    // DRAIN: abandoned request still in flight, target remembered.
    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } lc3b_fetch_state;

    localparam lc3b_word LC3B_RESET_PC = 16'h0000;

endpackage

// File: rtl/if_fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, runs the imem read handshake and
// presents {pc+PC_INC, instr} to ifid_pipe, honouring stall and redirect.
module if_fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word    RESET_PC = LC3B_RESET_PC,
    parameter int unsigned PC_INC   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_address,
    output logic        imem_read,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    output logic        ifid_load,
    output logic [31:0] ifid_in,
    output logic [15:0] fetch_pc
);

    lc3b_fetch_state state_q, state_d;
    lc3b_word        pc_q, pc_d;
    lc3b_word        redir_pc_q, redir_pc_d;
    lc3b_word        hold_instr_q, hold_instr_d;

    lc3b_word target;
    lc3b_word pc_next;

    assign target  = {redirect_pc[15:1], 1'b0};
    assign pc_next = pc_q + lc3b_word'(PC_INC);

    // Next-state and handshake outputs; reset forces every output idle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        hold_instr_d = hold_instr_q;
        imem_read    = 1'b0;
        imem_address = pc_q;
        ifid_load    = 1'b0;
        ifid_in      = 32'h0;
        fetch_pc     = pc_q;

        if (!reset) begin
            imem_address = 16'h0;
            fetch_pc     = RESET_PC;
        end else begin
            case (state_q)
                FETCH: begin
                    imem_read = 1'b1;
                    if (imem_resp) begin
                        if (redirect) begin
                            pc_d = target;
                        end else if (!stall) begin
                            ifid_load = 1'b1;
                            ifid_in   = {pc_next, imem_rdata};
                            pc_d      = pc_next;
                        end else begin
                            hold_instr_d = imem_rdata;
                            state_d      = HOLD;
                        end
                    end else if (redirect) begin
                        redir_pc_d = target;
                        state_d    = DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_d    = target;
                        state_d = FETCH;
                    end else if (!stall) begin
                        ifid_load = 1'b1;
                        ifid_in   = {pc_next, hold_instr_q};
                        pc_d      = pc_next;
                        state_d   = FETCH;
                    end
                end
                DRAIN: begin
                    // Address stays at pc so the abandoned request remains stable.
                    imem_read = 1'b1;
                    if (redirect) begin
                        redir_pc_d = target;
                    end
                    if (imem_resp) begin
                        pc_d    = redirect ? target : redir_pc_q;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            redir_pc_q   <= 16'h0;
            hold_instr_q <= 16'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table followed by randomized
// traffic compared against a transaction-level model of the fetch rules.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_address;
    logic        imem_read;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        ifid_load;
    logic [31:0] ifid_in;
    logic [15:0] fetch_pc;

    int checks = 0;
    int errors = 0;

    if_fetch_stage #(
        .RESET_PC(16'h0000),
        .PC_INC  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_address(imem_address),
        .imem_read   (imem_read),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .ifid_load   (ifid_load),
        .ifid_in     (ifid_in),
        .fetch_pc    (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stl;
        logic        rdr;
        logic [15:0] rpc;
        logic        rsp;
        logic [15:0] rdat;
        logic        e_read;
        logic [15:0] e_addr;
        logic        e_load;
        logic [31:0] e_ifid;
        logic [15:0] e_fpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic stl, logic rdr, logic [15:0] rpc,
                                logic rsp, logic [15:0] rdat, logic e_read,
                                logic [15:0] e_addr, logic e_load, logic [31:0] e_ifid,
                                logic [15:0] e_fpc);
        vec_t v;
        v.rst_n = rst_n; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rsp = rsp;
        v.rdat = rdat; v.e_read = e_read; v.e_addr = e_addr; v.e_load = e_load;
        v.e_ifid = e_ifid; v.e_fpc = e_fpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the fetch unit owes the pipeline, tracked as
    // facts (a parked word, an abandoned request and where to go after it).
    logic [15:0] m_pc;
    logic        m_parked;
    logic [15:0] m_parked_word;
    logic        m_abandoned;
    logic [15:0] m_after;
    logic        x_read;
    logic [15:0] x_addr;
    logic        x_load;
    logic [31:0] x_ifid;
    logic [15:0] x_fpc;

    task automatic model_reset();
        m_pc = 16'h0000; m_parked = 1'b0; m_parked_word = 16'h0;
        m_abandoned = 1'b0; m_after = 16'h0;
    endtask

    task automatic model_cycle(input logic rst_n, input logic stl, input logic rdr,
                               input logic [15:0] rpc, input logic rsp,
                               input logic [15:0] rdat);
        logic [15:0] tgt;
        tgt = rpc & 16'hFFFE;
        x_load = 1'b0; x_ifid = 32'h0;
        if (!rst_n) begin
            x_read = 1'b0; x_addr = 16'h0; x_fpc = 16'h0000;
            model_reset();
            return;
        end
        x_read = !m_parked;
        x_addr = m_pc;
        x_fpc  = m_pc;
        if (m_parked) begin
            if (rdr) begin
                m_pc = tgt; m_parked = 1'b0;
            end else if (!stl) begin
                x_load = 1'b1; x_ifid = {16'(m_pc + 16'd2), m_parked_word};
                m_pc = 16'(m_pc + 16'd2); m_parked = 1'b0;
            end
        end else if (m_abandoned) begin
            if (rdr) m_after = tgt;
            if (rsp) begin
                m_pc = m_after; m_abandoned = 1'b0;
            end
        end else if (rsp) begin
            if (rdr) m_pc = tgt;
            else if (!stl) begin
                x_load = 1'b1; x_ifid = {16'(m_pc + 16'd2), rdat};
                m_pc = 16'(m_pc + 16'd2);
            end else begin
                m_parked = 1'b1; m_parked_word = rdat;
            end
        end else if (rdr) begin
            m_abandoned = 1'b1; m_after = tgt;
        end
    endtask

    task automatic drive(input logic rst_n, input logic stl, input logic rdr,
                         input logic [15:0] rpc, input logic rsp, input logic [15:0] rdat);
        reset = rst_n; stall = stl; redirect = rdr; redirect_pc = rpc;
        imem_resp = rsp; imem_rdata = rdat;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);

        // rst stl rdr rpc rsp rdata | read addr load ifid fpc
        vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(1,0,0,16'h0000,1,16'h1234, 1,16'h0000,1,32'h0002_1234,16'h0000));
        vecs.push_back(mk(1,0,0,16'h0000,1,16'h5678, 1,16'h0002,1,32'h0004_5678,16'h0002));
        vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(1,1,0,16'h0000,1,16'hABCD, 1,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(1,1,0,16'h0000,1,16'h1111, 0,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(1,1,0,16'h0000,0,16'h0000, 0,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 0,16'h0000,1,32'h0002_ABCD,16'h0000));
        vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0002,0,32'h0,16'h0002));
        vecs.push_back(mk(1,0,1,16'h0040,0,16'h0000, 1,16'h0002,0,32'h0,16'h0002));
        vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0002,0,32'h0,16'h0002));
        vecs.push_back(mk(1,0,0,16'h0000,1,16'hDEAD, 1,16'h0002,0,32'h0,16'h0002));
        vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0040,0,32'h0,16'h0040));
        vecs.push_back(mk(1,0,1,16'h0010,1,16'h1111, 1,16'h0040,0,32'h0,16'h0040));
        vecs.push_back(mk(1,1,1,16'h0101,1,16'h2222, 1,16'h0010,0,32'h0,16'h0010));
        vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0100,0,32'h0,16'h0100));
        vecs.push_back(mk(1,0,1,16'hFFFE,1,16'h0000, 1,16'h0100,0,32'h0,16'h0100));
        vecs.push_back(mk(1,0,0,16'h0000,1,16'h7777, 1,16'hFFFE,1,32'h0000_7777,16'hFFFE));
        vecs.push_back(mk(1,0,0,16'h0000,1,16'h3333, 1,16'h0000,1,32'h0002_3333,16'h0000));
        vecs.push_back(mk(1,0,1,16'h0200,0,16'h0000, 1,16'h0002,0,32'h0,16'h0002));
        vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(1,1,0,16'h0000,1,16'h4444, 1,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(1,1,1,16'h0031,0,16'h0000, 0,16'h0000,0,32'h0,16'h0000));
        vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0030,0,32'h0,16'h0030));
        vecs.push_back(mk(1,0,1,16'h0050,0,16'h0000, 1,16'h0030,0,32'h0,16'h0030));
        vecs.push_back(mk(1,0,1,16'h0060,1,16'h5555, 1,16'h0030,0,32'h0,16'h0030));
        vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0060,0,32'h0,16'h0060));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst_n, vecs[i].stl, vecs[i].rdr, vecs[i].rpc, vecs[i].rsp,
                  vecs[i].rdat);
            #1;
            chk($sformatf("vec%0d imem_read", i), 32'(imem_read), 32'(vecs[i].e_read));
            if (vecs[i].e_read)
                chk($sformatf("vec%0d imem_address", i), 32'(imem_address),
                    32'(vecs[i].e_addr));
            chk($sformatf("vec%0d ifid_load", i), 32'(ifid_load), 32'(vecs[i].e_load));
            chk($sformatf("vec%0d ifid_in", i), ifid_in, vecs[i].e_ifid);
            chk($sformatf("vec%0d fetch_pc", i), 32'(fetch_pc), 32'(vecs[i].e_fpc));
        end

        // Randomized phase: start from reset, then free-running traffic.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic r_rst, r_stl, r_rdr, r_rsp;
            logic [15:0] r_rpc, r_dat;
            r_rst = (c < 2) ? 1'b0 : ($urandom_range(0, 63) != 0);
            r_stl = ($urandom_range(0, 2) == 0);
            r_rdr = ($urandom_range(0, 7) == 0);
            r_rsp = ($urandom_range(0, 1) == 0);
            r_rpc = 16'($urandom);
            r_dat = 16'($urandom);
            @(posedge clk);
            #1;
            drive(r_rst, r_stl, r_rdr, r_rpc, r_rsp, r_dat);
            model_cycle(r_rst, r_stl, r_rdr, r_rpc, r_rsp, r_dat);
            #1;
            checks++;
            if (imem_read !== x_read || (x_read && imem_address !== x_addr) ||
                ifid_load !== x_load || ifid_in !== x_ifid || fetch_pc !== x_fpc) begin
                errors++;
                $display("FAIL rand%0d: got read=%b addr=%h load=%b ifid=%h pc=%h expected read=%b addr=%h load=%b ifid=%h pc=%h",
                         c, imem_read, imem_address, ifid_load, ifid_in, fetch_pc,
                         x_read, x_addr, x_load, x_ifid, x_fpc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
